// File: rtl/imem_loader_pkg.sv
// rtl/imem_loader_pkg.sv - shared states and frame constants for the instruction memory loader
package imem_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LEN_HI = 3'd1,
        ST_LEN_LO = 3'd2,
        ST_DATA   = 3'd3,
        ST_CHECK  = 3'd4,
        ST_DONE   = 3'd5,
        ST_ERROR  = 3'd6
    } state_t;

    localparam int HDR_BYTES = 2;

    function automatic logic is_active(input state_t s);
        return (s == ST_LEN_HI) || (s == ST_LEN_LO) || (s == ST_DATA) || (s == ST_CHECK);
    endfunction

endpackage

// File: rtl/byte_timeout.sv
// rtl/byte_timeout.sv - inter-byte watchdog counter with clear input and limit-hit output
module byte_timeout #(
    parameter int LIMIT = 65535,
    parameter int CNT_W = $clog2(LIMIT + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic hit
);

    logic [CNT_W-1:0] count;

    // Saturates at LIMIT so hit stays asserted until the owner clears it.
    always_ff @(posedge clk) begin
        if (!rst || clr) begin
            count <= '0;
        end else if (en && !hit) begin
            count <= count + 1'b1;
        end
    end

    assign hit = (count == CNT_W'(LIMIT));

endmodule

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - byte-stream frame loader that fills instruction memory and releases the CPU
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int DEPTH   = 256,
    parameter int ADDR_W  = 8,
    parameter int TIMEOUT = 65535
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_rst,
    output logic              busy,
    output logic              done,
    output logic              err
);

    state_t      state, state_next;
    logic        active;
    logic        xfer;
    logic        start_ok;
    logic        to_hit;
    logic        to_en;
    logic        to_clr;
    logic        len_bad;
    logic        last_word;
    logic [7:0]  len_hi;
    logic [15:0] len;
    logic [15:0] len_n;
    logic [15:0] word_cnt;
    logic [1:0]  byte_cnt;
    logic [7:0]  csum;
    logic [31:0] shift_reg;

    assign active    = is_active(state);
    assign xfer      = byte_valid && active;
    assign start_ok  = start && ((state == ST_IDLE) || (state == ST_DONE) || (state == ST_ERROR));
    assign len_n     = {len_hi, byte_data};
    assign len_bad   = (len_n == 16'd0) || ({16'd0, len_n} > 32'(DEPTH));
    assign last_word = ((word_cnt + 16'd1) == len);

    // The watchdog only runs while a frame is in flight; any transfer restarts it.
    assign to_en  = active && !xfer;
    assign to_clr = !active || xfer;

    byte_timeout #(
        .LIMIT (TIMEOUT)
    ) u_byte_timeout (
        .clk (clk),
        .rst (rst),
        .en  (to_en),
        .clr (to_clr),
        .hit (to_hit)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        byte_ready = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        err        = 1'b0;
        cpu_rst    = 1'b0;
        unique case (state)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (start) begin
                    state_next = ST_LEN_HI;
                end
            end
            ST_LEN_HI: begin
                if (xfer) begin
                    state_next = ST_LEN_LO;
                end else if (to_hit) begin
                    state_next = ST_ERROR;
                end
            end
            ST_LEN_LO: begin
                if (xfer) begin
                    state_next = len_bad ? ST_ERROR : ST_DATA;
                end else if (to_hit) begin
                    state_next = ST_ERROR;
                end
            end
            ST_DATA: begin
                if (xfer) begin
                    if ((byte_cnt == 2'd3) && last_word) begin
                        state_next = ST_CHECK;
                    end
                end else if (to_hit) begin
                    state_next = ST_ERROR;
                end
            end
            ST_CHECK: begin
                if (xfer) begin
                    state_next = (byte_data == csum) ? ST_DONE : ST_ERROR;
                end else if (to_hit) begin
                    state_next = ST_ERROR;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
        byte_ready = active;
        busy       = active;
        done       = (state == ST_DONE);
        err        = (state == ST_ERROR);
        cpu_rst    = (state == ST_DONE);
    end

    // Word assembly and write strobe; the strobe lands the cycle after the fourth byte.
    always_ff @(posedge clk) begin
        if (!rst) begin
            imem_we   <= 1'b0;
            imem_addr <= '0;
            shift_reg <= '0;
            len_hi    <= '0;
            len       <= '0;
            word_cnt  <= '0;
            byte_cnt  <= '0;
            csum      <= '0;
        end else begin
            imem_we <= 1'b0;
            if (start_ok) begin
                csum      <= '0;
                byte_cnt  <= '0;
                word_cnt  <= '0;
                imem_addr <= '0;
            end
            if (xfer) begin
                case (state)
                    ST_LEN_HI: len_hi <= byte_data;
                    ST_LEN_LO: len    <= len_n;
                    ST_DATA: begin
                        shift_reg <= {shift_reg[23:0], byte_data};
                        csum      <= csum ^ byte_data;
                        byte_cnt  <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) begin
                            imem_we   <= 1'b1;
                            imem_addr <= ADDR_W'(word_cnt);
                            word_cnt  <= word_cnt + 16'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign imem_wdata = shift_reg;

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - self-checking bench for imem_loader with a write scoreboard
module tb_imem_loader;
    import imem_loader_pkg::*;

    localparam int DEPTH   = 256;
    localparam int ADDR_W  = 8;
    localparam int TIMEOUT = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              start = 1'b0;
    logic              byte_valid = 1'b0;
    logic [7:0]        byte_data = 8'h00;
    logic              byte_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              cpu_rst;
    logic              busy;
    logic              done;
    logic              err;

    imem_loader #(
        .DEPTH   (DEPTH),
        .ADDR_W  (ADDR_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_rst    (cpu_rst),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    typedef struct {
        logic [15:0] n;
        logic [31:0] w0;
        logic [31:0] w1;
        bit          csum_fixed;
        logic [7:0]  csum_byte;
        bit          rand_valid;
        bit          exp_done;
    } vec_t;

    wr_t  exp_q[$];
    vec_t vecs[7];
    int   vectors = 0;
    int   miscompares = 0;

    function automatic void check1(input string name, input logic act, input logic exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %b, want %b", name, act, exp);
        end
    endfunction

    function automatic void checkw(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endfunction

    function automatic logic [31:0] word_of(input int i, input logic [31:0] w0, input logic [31:0] w1);
        logic [31:0] iv;
        iv = i;
        if (i == 0) return w0;
        if (i == 1) return w1;
        return {iv[7:0] ^ 8'hA5, iv[15:8], ~iv[7:0], 8'h3C};
    endfunction

    // Scoreboard: every observed write must match the oldest expected one.
    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL stray_write: write at addr 0x%0h data 0x%0h, want none", imem_addr, imem_wdata);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                checkw("wr_addr", 32'(imem_addr), e.addr);
                checkw("wr_data", imem_wdata, e.data);
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input int gap);
        int guard;
        byte_valid = 1'b0;
        repeat (gap) @(negedge clk);
        byte_valid = 1'b1;
        byte_data  = b;
        guard = 0;
        while (byte_ready !== 1'b1 && guard < 64) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 64) begin
            vectors++;
            miscompares++;
            $display("FAIL byte_ready_wait: byte_ready %b, want 1", byte_ready);
        end
        @(negedge clk);
        byte_valid = 1'b0;
        byte_data  = 8'($urandom);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check1({tag, "_byte_ready"}, byte_ready, 1'b0);
        check1({tag, "_imem_we"}, imem_we, 1'b0);
        checkw({tag, "_imem_addr"}, 32'(imem_addr), 32'd0);
        checkw({tag, "_imem_wdata"}, imem_wdata, 32'd0);
        check1({tag, "_cpu_rst"}, cpu_rst, 1'b0);
        check1({tag, "_busy"}, busy, 1'b0);
        check1({tag, "_done"}, done, 1'b0);
        check1({tag, "_err"}, err, 1'b0);
    endtask

    task automatic run_frame(input vec_t v);
        logic [7:0]  x;
        logic [31:0] w;
        logic [7:0]  hdr [HDR_BYTES];
        int          gap;
        x = 8'h00;
        hdr[0] = v.n[15:8];
        hdr[1] = v.n[7:0];
        pulse_start();
        for (int h = 0; h < HDR_BYTES; h++) send_byte(hdr[h], 0);
        if (v.n == 16'd0 || int'(v.n) > DEPTH) begin
            check1("len_err", err, 1'b1);
            check1("len_busy", busy, 1'b0);
            repeat (3) @(negedge clk);
            check1("len_err_hold", err, 1'b1);
            check1("len_cpu_rst", cpu_rst, 1'b0);
            return;
        end
        for (int i = 0; i < int'(v.n); i++) begin
            w = word_of(i, v.w0, v.w1);
            exp_q.push_back('{addr: 32'(i), data: w});
            for (int k = 0; k < 4; k++) begin
                gap = v.rand_valid ? int'($urandom_range(0, 3)) : 0;
                x = x ^ w[31 - 8*k -: 8];
                send_byte(w[31 - 8*k -: 8], gap);
            end
        end
        gap = v.rand_valid ? int'($urandom_range(0, 3)) : 0;
        send_byte(v.csum_fixed ? v.csum_byte : (x ^ v.csum_byte), gap);
        check1("frame_done", done, v.exp_done);
        check1("frame_err", err, !v.exp_done);
        check1("frame_cpu_rst", cpu_rst, v.exp_done);
        check1("frame_busy", busy, 1'b0);
        checkw("frame_writes_left", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        logic [31:0] w;
        logic [7:0]  x;
        int          guard;

        vecs[0] = '{n: 16'd2,   w0: 32'h2008_0005, w1: 32'h0109_4020, csum_fixed: 1'b1, csum_byte: 8'h45, rand_valid: 1'b0, exp_done: 1'b1};
        vecs[1] = '{n: 16'd2,   w0: 32'h2008_0005, w1: 32'h0109_4020, csum_fixed: 1'b1, csum_byte: 8'h0D, rand_valid: 1'b0, exp_done: 1'b0};
        vecs[2] = '{n: 16'd0,   w0: 32'h0,         w1: 32'h0,         csum_fixed: 1'b0, csum_byte: 8'h00, rand_valid: 1'b0, exp_done: 1'b0};
        vecs[3] = '{n: 16'd257, w0: 32'h0,         w1: 32'h0,         csum_fixed: 1'b0, csum_byte: 8'h00, rand_valid: 1'b0, exp_done: 1'b0};
        vecs[4] = '{n: 16'd1,   w0: 32'hFFFF_FFFF, w1: 32'h0,         csum_fixed: 1'b0, csum_byte: 8'h00, rand_valid: 1'b0, exp_done: 1'b1};
        vecs[5] = '{n: 16'd256, w0: 32'h1234_5678, w1: 32'h9ABC_DEF0, csum_fixed: 1'b0, csum_byte: 8'h00, rand_valid: 1'b1, exp_done: 1'b1};
        vecs[6] = '{n: 16'd3,   w0: 32'h0BAD_F00D, w1: 32'h7654_3210, csum_fixed: 1'b0, csum_byte: 8'h80, rand_valid: 1'b1, exp_done: 1'b0};

        rst = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b1;
        @(negedge clk);

        for (int t = 0; t < 7; t++) run_frame(vecs[t]);

        // Watchdog expiry mid-word: nothing may be written.
        pulse_start();
        send_byte(8'h00, 0);
        send_byte(8'h02, 0);
        send_byte(8'h20, 0);
        send_byte(8'h08, 0);
        repeat (TIMEOUT - 1) @(negedge clk);
        check1("to_not_yet", err, 1'b0);
        check1("to_busy", busy, 1'b1);
        guard = 0;
        while (err !== 1'b1 && guard < 4) begin
            @(negedge clk);
            guard++;
        end
        check1("to_err", err, 1'b1);
        check1("to_cpu_rst", cpu_rst, 1'b0);

        // Transfer coinciding with the watchdog limit wins; a mid-frame start is ignored.
        pulse_start();
        repeat (TIMEOUT) @(negedge clk);
        check1("lim_busy", busy, 1'b1);
        send_byte(8'h00, 0);
        check1("lim_xfer_no_err", err, 1'b0);
        pulse_start();
        send_byte(8'h01, 0);
        w = 32'hCAFE_F00D;
        x = 8'h00;
        exp_q.push_back('{addr: 32'd0, data: w});
        for (int k = 0; k < 4; k++) begin
            x = x ^ w[31 - 8*k -: 8];
            send_byte(w[31 - 8*k -: 8], 0);
        end
        send_byte(x, 0);
        check1("lim_done", done, 1'b1);
        checkw("lim_writes_left", 32'(exp_q.size()), 32'd0);

        // Reset lands on the edge that would have taken the last byte of word 1.
        pulse_start();
        send_byte(8'h00, 0);
        send_byte(8'h02, 0);
        w = 32'h2008_0005;
        exp_q.push_back('{addr: 32'd0, data: w});
        for (int k = 0; k < 4; k++) send_byte(w[31 - 8*k -: 8], 0);
        send_byte(8'h01, 0);
        send_byte(8'h09, 0);
        send_byte(8'h40, 0);
        byte_valid = 1'b1;
        byte_data  = 8'h20;
        rst = 1'b0;
        @(negedge clk);
        byte_valid = 1'b0;
        check_reset_outputs("midrst");
        @(negedge clk);
        check1("midrst_no_we", imem_we, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        checkw("midrst_writes_left", 32'(exp_q.size()), 32'd0);
        run_frame(vecs[0]);

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
        $fatal(1, "bench timeout");
    end

endmodule
